// File: rtl/ram_harvard_pkg.sv
// ram_harvard_pkg: shared constants and types for the Harvard RAM model.
//   - Region map: four CPU address windows folded into one 8 KB byte store.
//   - MEM_BYTES: size of the byte store.
//   - TRAP_WORD: word returned for unmapped addresses when the
//     RAM_UNMAPPED_TRAP_EN build option is defined.
//   - state_t: data-port handshake states.
package ram_harvard_pkg;

    localparam int unsigned MEM_BYTES = 8192;

    // Region windows (inclusive limits) and their starting byte offset in
    // the store. Windows are packed back to back with no gaps.
    localparam logic [31:0] R0_BASE   = 32'h0000_0000;
    localparam logic [31:0] R0_LIMIT  = 32'h0000_03FF;
    localparam logic [12:0] R0_OFFSET = 13'h0000;

    localparam logic [31:0] R1_BASE   = 32'h8000_0000;
    localparam logic [31:0] R1_LIMIT  = 32'h8000_07FF;
    localparam logic [12:0] R1_OFFSET = 13'h0400;

    localparam logic [31:0] R2_BASE   = 32'hBFBF_F800;
    localparam logic [31:0] R2_LIMIT  = 32'hBFC0_07FF;
    localparam logic [12:0] R2_OFFSET = 13'h0C00;

    localparam logic [31:0] R3_BASE   = 32'hFFFF_FC00;
    localparam logic [12:0] R3_OFFSET = 13'h1C00;

    localparam logic [31:0] TRAP_WORD = 32'hDEAD_BEEF;

    typedef enum logic {IDLE, WAIT} state_t;

endpackage

// File: rtl/ram_addr_map.sv
// ram_addr_map: folds a 32-bit CPU byte address onto the 8 KB store.
//   address    : CPU byte address; bits [1:0] are ignored
//   word_index : word index into the store (byte index = {word_index, 2'b00})
//   mapped     : high when the address falls inside one of the four windows;
//                unmapped addresses alias to address[12:2]
module ram_addr_map
    import ram_harvard_pkg::*;
(
    input  logic [31:0] address,
    output logic [10:0] word_index,
    output logic        mapped
);

    // All arithmetic is done on word indices: bases and offsets are word
    // aligned and every window fits in 8 KB, so 11-bit wraparound is exact.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        word_index = address[12:2];
        mapped     = 1'b0;
        if (address <= R0_LIMIT) begin
            mapped     = 1'b1;
            word_index = address[12:2] - R0_BASE[12:2] + R0_OFFSET[12:2];
        end else if (address >= R1_BASE && address <= R1_LIMIT) begin
            mapped     = 1'b1;
            word_index = address[12:2] - R1_BASE[12:2] + R1_OFFSET[12:2];
        end else if (address >= R2_BASE && address <= R2_LIMIT) begin
            mapped     = 1'b1;
            word_index = address[12:2] - R2_BASE[12:2] + R2_OFFSET[12:2];
        end else if (address >= R3_BASE) begin
            mapped     = 1'b1;
            word_index = address[12:2] - R3_BASE[12:2] + R3_OFFSET[12:2];
        end
    end

endmodule

// File: rtl/ram_harvard_waitstate.sv
// ram_harvard_waitstate: unified 8 KB instruction/data RAM for the MIPS CPU
// testbench, with a zero-delay fetch port and a wait-state data port.
//   clk, reset         : rising-edge clock, async active-high reset (FSM only;
//                        memory contents survive reset)
//   instr_address      : fetch byte address
//   instr_readdata     : fetched little-endian word (combinational)
//   data_address       : load/store byte address
//   data_read/write    : load / store request (both high = store)
//   data_byteenable    : per-byte store enable
//   data_writedata     : store data
//   data_waitrequest   : high while the access is not yet complete
//   data_readdata      : load data, valid in the completing cycle, else 0
// Parameters: DATA_WAIT_CYCLES wait states per data access (0 = zero delay),
// COUNT_W wait counter width (2**COUNT_W > DATA_WAIT_CYCLES), RAM_INIT_FILE
// names the image the simulation environment preloads into the store.
// Build option: RAM_UNMAPPED_TRAP_EN makes unmapped addresses read TRAP_WORD,
// drops unmapped stores and reports each unmapped data access.
module ram_harvard_waitstate
    import ram_harvard_pkg::*;
#(
    parameter string RAM_INIT_FILE    = "",
    parameter int    DATA_WAIT_CYCLES = 0,
    parameter int    COUNT_W          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata
);

    localparam logic [COUNT_W-1:0] WAIT_N = COUNT_W'(DATA_WAIT_CYCLES);

    logic [7:0]         mem [0:MEM_BYTES-1];
    logic [10:0]        instr_widx, data_widx;
    logic               instr_mapped, data_mapped;
    logic [31:0]        instr_word, data_word;
    state_t             state, state_n;
    logic [COUNT_W-1:0] cnt, cnt_n;
    logic               req, complete, store_en;

    ram_addr_map u_instr_map (
        .address    (instr_address),
        .word_index (instr_widx),
        .mapped     (instr_mapped)
    );

    ram_addr_map u_data_map (
        .address    (data_address),
        .word_index (data_widx),
        .mapped     (data_mapped)
    );

    assign instr_word = {mem[{instr_widx, 2'd3}], mem[{instr_widx, 2'd2}],
                         mem[{instr_widx, 2'd1}], mem[{instr_widx, 2'd0}]};
    assign data_word  = {mem[{data_widx, 2'd3}], mem[{data_widx, 2'd2}],
                         mem[{data_widx, 2'd1}], mem[{data_widx, 2'd0}]};

    assign req = data_read | data_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge value of every other flop.
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Dropping the request while in WAIT abandons the access. Reset forces
    // IDLE asynchronously, so a store caught mid-WAIT never reaches completion.
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        data_waitrequest = 1'b0;
        complete         = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (DATA_WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        data_waitrequest = 1'b1;
                        cnt_n            = COUNT_W'(1);
                        state_n          = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt < WAIT_N) begin
                    data_waitrequest = 1'b1;
                    cnt_n            = cnt + COUNT_W'(1);
                end else begin
                    complete = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end
            end
        endcase
    end

    // Gating with reset discards a zero-wait store whose edge coincides with reset.
`ifdef RAM_UNMAPPED_TRAP_EN
    assign store_en       = complete & data_write & data_mapped & ~reset;
    assign instr_readdata = instr_mapped ? instr_word : TRAP_WORD;
    assign data_readdata  = (complete && data_read)
                          ? (data_mapped ? data_word : TRAP_WORD) : '0;

    always_ff @(posedge clk) begin
        if (complete && !data_mapped && !reset)
            $display("ram_harvard_waitstate: unmapped data access at %h", data_address);
    end
`else
    logic unused_mapped;
    assign unused_mapped  = &{1'b0, instr_mapped, data_mapped};
    assign store_en       = complete & data_write & ~reset;
    assign instr_readdata = instr_word;
    assign data_readdata  = (complete && data_read) ? data_word : '0;
`endif

    // NOTE: the byte store has no reset branch; reset leaves contents intact,
    // and a reset on a large array would also defeat RAM inference.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_byteenable[b])
                    mem[{data_widx, 2'(b)}] <= data_writedata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ram_harvard_waitstate.sv
module tb_ram_harvard_waitstate;

`ifdef RAM_UNMAPPED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Instance k runs with wait_of(k) data wait states.
    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    typedef struct {
        int          inst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr  [3];
    logic [31:0] i_rdata [3];
    logic [31:0] d_addr  [3];
    logic        d_rd    [3];
    logic        d_wr    [3];
    logic [3:0]  d_be    [3];
    logic [31:0] d_wdata [3];
    logic        d_wait  [3];
    logic [31:0] d_rdata [3];

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_harvard_waitstate #(
            .RAM_INIT_FILE    (""),
            .DATA_WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 2 : 3),
            .COUNT_W          (4)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .instr_address    (i_addr[g]),
            .instr_readdata   (i_rdata[g]),
            .data_address     (d_addr[g]),
            .data_read        (d_rd[g]),
            .data_write       (d_wr[g]),
            .data_byteenable  (d_be[g]),
            .data_writedata   (d_wdata[g]),
            .data_waitrequest (d_wait[g]),
            .data_readdata    (d_rdata[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input string name);
        vec_t v;
        v.inst = inst; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.name = name;
        return v;
    endfunction

    // One complete handshake: drive after a rising edge, count wait cycles at
    // falling edges, capture readdata in the completing cycle, then release.
    task automatic access(input vec_t v);
        int          k;
        int          waits;
        bit          done;
        logic        dirty;
        logic [31:0] got;
        vec_t        e;
        k = v.inst;
        exp_q.push_back(v);
        @(posedge clk); #1;
        d_addr[k] = v.addr; d_rd[k] = v.rd; d_wr[k] = v.wr;
        d_be[k] = v.be; d_wdata[k] = v.wdata;
        waits = 0; done = 1'b0; dirty = 1'b0; got = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (d_wait[k]) begin
                waits++;
                if (d_rdata[k] !== 32'h0) dirty = 1'b1;
                @(posedge clk); #1;
            end else begin
                got  = d_rdata[k];
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        d_rd[k] = 1'b0; d_wr[k] = 1'b0;
        e = exp_q.pop_front();
        check({e.name, "_done"}, 32'(done), 32'd1);
        check({e.name, "_rdata"}, got, e.exp_rdata);
        check({e.name, "_waits"}, waits, wait_of(e.inst));
        check({e.name, "_rdata_while_wait"}, 32'(dirty), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr[k] = '0; d_addr[k] = '0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
            d_be[k] = '0; d_wdata[k] = '0;
        end

        vecs.push_back(mk(0, 0, 1, 32'hBFC0_0000, 4'hF, 32'h1234_5678, 32'h0, "w0_store"));
        vecs.push_back(mk(0, 1, 0, 32'hBFC0_0000, 4'h0, 32'h0, 32'h1234_5678, "w0_load"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0100, 4'hF, 32'hAABB_CCDD, 32'h0, "be_preload"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0100, 4'b0101, 32'h1122_3344, 32'h0, "be_0101"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0100, 4'h0, 32'h0, 32'hAA22_CC44, "be_readback"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0100, 4'h0, 32'hFFFF_FFFF, 32'h0, "be_none"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0100, 4'h0, 32'h0, 32'hAA22_CC44, "be_none_readback"));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, 4'hF, 32'h9988_7766, 32'hAA22_CC44, "rdwr_prestore"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0102, 4'h0, 32'h0, 32'h9988_7766, "rdwr_after_lowbits"));
        vecs.push_back(mk(0, 0, 1, 32'h8000_07FC, 4'hF, 32'hB0B0_B0B0, 32'h0, "edge_r1_top"));
        vecs.push_back(mk(0, 0, 1, 32'hBFBF_F800, 4'hF, 32'hC0C0_C0C0, 32'h0, "edge_r2_base"));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 4'hF, 32'hD0D0_D0D0, 32'h0, "edge_r3_top"));
        vecs.push_back(mk(0, 1, 0, 32'h8000_07FC, 4'h0, 32'h0, 32'hB0B0_B0B0, "edge_r1_read"));
        vecs.push_back(mk(0, 1, 0, 32'hBFBF_F800, 4'h0, 32'h0, 32'hC0C0_C0C0, "edge_r2_read"));
        vecs.push_back(mk(0, 1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'hD0D0_D0D0, "edge_r3_read"));
        vecs.push_back(mk(2, 0, 1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, 32'h0, "w3_store"));
        vecs.push_back(mk(2, 1, 0, 32'h8000_0010, 4'h0, 32'h0, 32'hCAFE_F00D, "w3_load"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0000, 4'hF, 32'h1111_0000, 32'h0, "unm_preload"));
        vecs.push_back(mk(0, 0, 1, 32'h4000_0000, 4'hF, 32'h5A5A_0001, 32'h0, "unm_store"));
        vecs.push_back(mk(0, 1, 0, 32'h4000_0000, 4'h0, 32'h0,
                          TRAP ? 32'hDEAD_BEEF : 32'h5A5A_0001, "unm_load"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0000, 4'h0, 32'h0,
                          TRAP ? 32'h1111_0000 : 32'h5A5A_0001, "unm_index0"));

        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_wait_%0d", k), 32'(d_wait[k]), 32'd0);
            check($sformatf("reset_rdata_%0d", k), d_rdata[k], 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[n]) access(vecs[n]);

        // Fetch port sees the zero-wait store and the unmapped fetch behaviour.
        i_addr[0] = 32'hBFC0_0000;
        #1 check("instr_w0", i_rdata[0], 32'h1234_5678);
        i_addr[0] = 32'h4000_0000;
        #1 check("instr_unmapped", i_rdata[0], TRAP ? 32'hDEAD_BEEF : 32'h5A5A_0001);

        // Same-word fetch during the completing store cycle shows the old word.
        access(mk(0, 0, 1, 32'hBFC0_0004, 4'hF, 32'h7777_7777, 32'h0, "same_old"));
        i_addr[0] = 32'hBFC0_0004;
        @(posedge clk); #1;
        d_addr[0] = 32'hBFC0_0004; d_wr[0] = 1'b1; d_be[0] = 4'hF; d_wdata[0] = 32'h8888_8888;
        @(negedge clk);
        check("same_wait", 32'(d_wait[0]), 32'd0);
        check("same_instr_old", i_rdata[0], 32'h7777_7777);
        @(posedge clk); #1;
        d_wr[0] = 1'b0;
        check("same_instr_new", i_rdata[0], 32'h8888_8888);

        // Reset during the second wait cycle of a store discards it.
        access(mk(1, 0, 1, 32'hFFFF_FC00, 4'hF, 32'h0102_0304, 32'h0, "rst_pre"));
        @(posedge clk); #1;
        d_addr[1] = 32'hFFFF_FC00; d_wr[1] = 1'b1; d_be[1] = 4'hF; d_wdata[1] = 32'hA5A5_A5A5;
        @(negedge clk);
        check("rst_c0_wait", 32'(d_wait[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        d_wr[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        i_addr[1] = 32'hFFFF_FC00;
        #1 check("rst_wait_idle", 32'(d_wait[1]), 32'd0);
        check("rst_mem_kept", i_rdata[1], 32'h0102_0304);
        access(mk(1, 0, 1, 32'hFFFF_FC00, 4'hF, 32'hC3C3_C3C3, 32'h0, "rst_fresh"));
        check("rst_fresh_mem", i_rdata[1], 32'hC3C3_C3C3);

        // Request dropped after one wait cycle: abandoned, no write.
        access(mk(1, 0, 1, 32'hFFFF_FC04, 4'hF, 32'h0BAD_F00D, 32'h0, "drop_pre"));
        i_addr[1] = 32'hFFFF_FC04;
        @(posedge clk); #1;
        d_addr[1] = 32'hFFFF_FC04; d_wr[1] = 1'b1; d_be[1] = 4'hF; d_wdata[1] = 32'h5555_5555;
        @(negedge clk);
        check("drop_c0_wait", 32'(d_wait[1]), 32'd1);
        @(posedge clk); #1;
        d_wr[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_wait_low", 32'(d_wait[1]), 32'd0);
        check("drop_mem_kept", i_rdata[1], 32'h0BAD_F00D);
        access(mk(1, 1, 0, 32'hFFFF_FC04, 4'h0, 32'h0, 32'h0BAD_F00D, "drop_reload"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
